tx_encoder: RTL and testbench

TX_ENCODER -- requirements
Module: tx_encoder

---
 rtl/tx_encoder.sv | 189 ++++++++++++++++++
 tb/tb_tx_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_encoder.sv
// USB low-level transmit encoder: serialises bytes LSB first, applies NRZI
// coding with bit stuffing, and closes each packet with an SE0/SE0/J EOP.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line at J, waiting for the first byte of a packet
// SEND    | transmitting a data bit period
// STUFF   | transmitting a forced-toggle stuff bit after six ones
// EOP_SE0 | both lines low for two bit periods
// EOP_J   | line at J for one bit period before returning to IDLE
module tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       eop_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_END = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SEND, STUFF, EOP_SE0, EOP_J} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [2:0]      ones_q, ones_d;
  logic            line_q, line_d;     // NRZI line level, 1 = J
  logic            last_q, last_d;
  logic            se0_cnt_q, se0_cnt_d;
  logic            dp_q, dp_d;
  logic            dm_q, dm_d;
  logic            eop_done_q, eop_done_d;

  logic            bit_end, boundary, load, next_bit, launch, goto_eop;
  logic            bit_val, ready_int, se0;
  logic [2:0]      ones_base;

  assign bit_end  = (timer_q == T_END);
  assign tx_busy  = (state_q != IDLE);
  assign d_plus   = dp_q;
  assign d_minus  = dm_q;
  assign eop_done = eop_done_q;

  // Next-state, bit sequencing, NRZI/stuffing and handshake decode
  always_comb begin
    state_d    = state_q;
    timer_d    = bit_end ? '0 : timer_q + TW'(1);
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    ones_d     = ones_q;
    line_d     = line_q;
    last_d     = last_q;
    se0_cnt_d  = se0_cnt_q;
    eop_done_d = 1'b0;
    ready_int  = 1'b0;
    boundary   = 1'b0;
    load       = 1'b0;
    next_bit   = 1'b0;
    launch     = 1'b0;
    goto_eop   = 1'b0;
    bit_val    = 1'b0;
    ones_base  = ones_q;

    case (state_q)
      IDLE: begin
        timer_d   = '0;
        line_d    = 1'b1;
        ready_int = 1'b1;
        load      = tx_valid;
      end
      SEND: begin
        if (bit_end) begin
          if (ones_q == 3'd6) begin
            state_d = STUFF;
            line_d  = ~line_q;
            ones_d  = '0;
          end else if (bit_idx_q == 3'd7) begin
            boundary = 1'b1;
          end else begin
            next_bit = 1'b1;
          end
        end
      end
      STUFF: begin
        // bit_idx_q still names the data bit before the stuff bit
        if (bit_end) begin
          if (bit_idx_q == 3'd7) boundary = 1'b1;
          else                   next_bit = 1'b1;
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (se0_cnt_q) state_d   = EOP_J;
          else           se0_cnt_d = 1'b1;
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_d    = IDLE;
          eop_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (boundary) begin
      if (last_q) begin
        goto_eop = 1'b1;
      end else begin
        ready_int = 1'b1;
        if (tx_valid) load     = 1'b1;
        else          goto_eop = 1'b1;
      end
    end

    if (load) begin
      shift_d   = tx_data;
      last_d    = tx_last;
      bit_idx_d = '0;
      bit_val   = tx_data[0];
      launch    = 1'b1;
      if (state_q == IDLE) ones_base = '0;
    end

    if (next_bit) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + 3'd1;
      bit_val   = shift_q[1];
      launch    = 1'b1;
    end

    if (launch) begin
      state_d = SEND;
      line_d  = bit_val ? line_q : ~line_q;
      ones_d  = bit_val ? ones_base + 3'd1 : '0;
    end

    // Line returns to J here so EOP_J and the following IDLE drive J
    if (goto_eop) begin
      state_d   = EOP_SE0;
      se0_cnt_d = 1'b0;
      line_d    = 1'b1;
    end

    se0      = (state_d == EOP_SE0);
    dp_d     = line_d & ~se0;
    dm_d     = ~line_d & ~se0;
    tx_ready = ready_int & ~rst;
  end

  // State and datapath registers with synchronous reset to an idle J line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      ones_q     <= '0;
      line_q     <= 1'b1;
      last_q     <= 1'b0;
      se0_cnt_q  <= 1'b0;
      dp_q       <= 1'b1;
      dm_q       <= 1'b0;
      eop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      ones_q     <= ones_d;
      line_q     <= line_d;
      last_q     <= last_d;
      se0_cnt_q  <= se0_cnt_d;
      dp_q       <= dp_d;
      dm_q       <= dm_d;
      eop_done_q <= eop_done_d;
    end
  end

endmodule

// File: tb/tb_tx_encoder.sv
// Bench for tx_encoder: a line-symbol scoreboard filled from a reference
// NRZI/stuffing model, checked once per bit period while the encoder is busy.
module tb_tx_encoder;

  localparam int CPB = 8;
  localparam logic [1:0] S_J   = 2'b10;
  localparam logic [1:0] S_SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus, d_minus, tx_busy, eop_done;

  tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .tx_busy  (tx_busy),
    .eop_done (eop_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  logic [1:0] exp_q[$];
  logic [7:0] pkt[$];
  int         exp_len  = 0;
  int         exp_rdy  = 0;
  int         eop_cnt  = 0;
  int         pkt_done = 0;
  int         bcyc     = 0;
  int         rdy_cnt  = 0;
  logic       was_busy = 1'b0;
  logic [1:0] cur      = 2'b10;

  // Reference encoder: expected line symbol for every bit period of pkt
  task automatic model_push(input bit underrun);
    logic line;
    int   ones;
    logic b;
    logic [7:0] byt;
    line = 1'b1;
    ones = 0;
    exp_q.delete();
    for (int i = 0; i < pkt.size(); i++) begin
      byt = pkt[i];
      for (int k = 0; k < 8; k++) begin
        b = byt[k];
        if (!b) line = ~line;
        exp_q.push_back({line, ~line});
        if (b) ones++;
        else   ones = 0;
        if (ones == 6) begin
          line = ~line;
          exp_q.push_back({line, ~line});
          ones = 0;
        end
      end
    end
    exp_q.push_back(S_SE0);
    exp_q.push_back(S_SE0);
    exp_q.push_back(S_J);
    exp_len = exp_q.size() * CPB;
    exp_rdy = underrun ? pkt.size() : pkt.size() - 1;
  endtask

  // Monitor: pops one expected symbol per bit period, checks packet wrap-up
  always @(negedge clk) begin
    if (rst) begin
      bcyc     = 0;
      was_busy = 1'b0;
      exp_q.delete();
    end else begin
      if (eop_done) eop_cnt++;
      if (tx_busy) begin
        if (!was_busy) rdy_cnt = 0;
        if (bcyc % CPB == 0) begin
          chk("sym_avail", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          chk("sym_start", 32'({d_plus, d_minus}), 32'(cur));
        end else if (bcyc % CPB == CPB - 1) begin
          chk("sym_end", 32'({d_plus, d_minus}), 32'(cur));
        end
        if (tx_ready) rdy_cnt++;
        bcyc++;
        was_busy = 1'b1;
      end else begin
        if (was_busy) begin
          chk("busy_len", bcyc, exp_len);
          chk("eop_done_first_idle", 32'(eop_done), 32'd1);
          chk("sym_left", exp_q.size(), 0);
          chk("rdy_pulses", rdy_cnt, exp_rdy);
          chk("idle_line", 32'({d_plus, d_minus}), 32'(S_J));
          pkt_done++;
        end
        bcyc     = 0;
        was_busy = 1'b0;
      end
    end
  end

  // Called at posedge+2; offers each byte of pkt until handshaken
  task automatic drive_pkt(input bit underrun);
    for (int i = 0; i < pkt.size(); i++) begin
      bit acc;
      int g;
      acc = 1'b0;
      g   = 0;
      tx_data  = pkt[i];
      tx_valid = 1'b1;
      tx_last  = (i == pkt.size() - 1) && !underrun;
      while (!acc && g < 400) begin
        @(negedge clk);
        acc = tx_ready;
        @(posedge clk);
        #2;
        g++;
      end
      chk("accept", 32'(acc), 32'd1);
      if (!acc) break;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b1;
    tx_data  = 8'($urandom);
  endtask

  task automatic run_pkt(input bit underrun);
    int d0, e0, g;
    d0 = pkt_done;
    e0 = eop_cnt;
    model_push(underrun);
    drive_pkt(underrun);
    g = 0;
    while (pkt_done == d0 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    #2;
    chk("pkt_done", pkt_done, d0 + 1);
    chk("eop_count", eop_cnt, e0 + 1);
    @(negedge clk);
    chk("idle_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int e0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dp", 32'(d_plus), 32'd1);
    chk("rst_dm", 32'(d_minus), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_eop", 32'(eop_done), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #2;

    pkt = '{8'h00};               run_pkt(1'b0);
    pkt = '{8'hFF};               run_pkt(1'b0);
    pkt = '{8'hE0, 8'h07};        run_pkt(1'b0);
    pkt = '{8'h55};               run_pkt(1'b1);
    pkt = '{8'h7F, 8'hFF, 8'hFC}; run_pkt(1'b0);

    // Abort during bit 4 of 0x33
    pkt = '{8'h33};
    model_push(1'b0);
    e0 = eop_cnt;
    drive_pkt(1'b0);
    repeat (34) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_before", 32'(tx_busy), 32'd1);
    @(negedge clk);
    chk("abort_dp", 32'(d_plus), 32'd1);
    chk("abort_dm", 32'(d_minus), 32'd0);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_ready", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    chk("abort_no_eop", eop_cnt, e0);

    pkt = '{8'hA5};               run_pkt(1'b0);
    for (int n = 0; n < 3; n++) begin
      pkt = '{8'($urandom), 8'($urandom), 8'($urandom)};
      run_pkt(n[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
